// File: rtl/enemy_formation_ctrl.sv
// Invader formation sequencer: owns the formation origin, alive mask, march
// direction and animation phase, stepping once every MOVE_DIV frame ticks.
module enemy_formation_ctrl #(
    parameter int COLS     = 8,
    parameter int ROWS     = 4,
    parameter int SPACING  = 32,
    parameter int SPRITE_W = 24,
    parameter int STEP_X   = 4,
    parameter int STEP_Y   = 16,
    parameter int MOVE_DIV = 8,
    parameter int X_START  = 64,
    parameter int Y_START  = 32,
    parameter int X_MIN    = 8,
    parameter int X_MAX    = 631,
    parameter int Y_LIMIT  = 400,
    localparam int N       = ROWS * COLS,
    localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          restart,
    input  logic          kill_valid,
    input  logic [IW-1:0] kill_idx,
    output logic [9:0]    base_x,
    output logic [9:0]    base_y,
    output logic [N-1:0]  alive_mask,
    output logic          anim_frame,
    output logic          step_pulse,
    output logic          wave_clear,
    output logic          reached_bottom
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    typedef enum logic [2:0] {MARCH_R, MARCH_L, DESC_TO_L, DESC_TO_R, HALT} state_t;

    state_t         state_reg, state_next;
    logic [9:0]     base_x_reg, base_x_next;
    logic [9:0]     base_y_reg, base_y_next;
    logic [N-1:0]   alive_reg, alive_next;
    logic           anim_reg, anim_next;
    logic           step_reg, step_next;
    logic           clear_reg, clear_next;
    logic           bottom_reg, bottom_next;
    logic [FW-1:0]  fcnt_reg, fcnt_next;

    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;
    logic [CW-1:0]   lcol, rcol;
    logic [RW-1:0]   brow;
    logic            step_tick, go_right;
    logic [10:0]     right_ext, left_ext, bottom_ext;

    // Occupancy per column and per row, from the mask before this cycle's kill
    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            logic [ROWS-1:0] bits;
            for (genvar gr = 0; gr < ROWS; gr++) begin : g_bit
                assign bits[gr] = alive_reg[gr*COLS + gi];
            end
            assign col_any[gi] = |bits;
        end
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            assign row_any[gi] = |alive_reg[gi*COLS +: COLS];
        end
    endgenerate

    always_comb begin
        lcol = '0;
        rcol = '0;
        brow = '0;
        for (int c = COLS - 1; c >= 0; c--) if (col_any[c]) lcol = CW'(c);
        for (int c = 0; c < COLS; c++)      if (col_any[c]) rcol = CW'(c);
        for (int r = 0; r < ROWS; r++)      if (row_any[r]) brow = RW'(r);
    end

    assign step_tick = frame_tick && (fcnt_reg == FW'(MOVE_DIV - 1));
    assign go_right  = (state_reg == MARCH_R) || (state_reg == DESC_TO_R);
    assign right_ext = {1'b0, base_x_reg} + 11'(rcol) * 11'(SPACING)
                     + 11'(SPRITE_W - 1 + STEP_X);
    assign left_ext  = {1'b0, base_x_reg} + 11'(lcol) * 11'(SPACING);

    always_comb begin
        state_next  = state_reg;
        base_x_next = base_x_reg;
        base_y_next = base_y_reg;
        alive_next  = alive_reg;
        anim_next   = anim_reg;
        step_next   = 1'b0;
        clear_next  = clear_reg;
        bottom_next = bottom_reg;
        fcnt_next   = fcnt_reg;
        bottom_ext  = '0;
        if (state_reg != HALT) begin
            if (state_reg == DESC_TO_L) state_next = MARCH_L;
            if (state_reg == DESC_TO_R) state_next = MARCH_R;
            if (frame_tick) fcnt_next = step_tick ? '0 : fcnt_reg + 1'b1;
            if (step_tick) begin
                anim_next = ~anim_reg;
                step_next = 1'b1;
                if (go_right) begin
                    if (right_ext > 11'(X_MAX)) begin
                        base_y_next = base_y_reg + 10'(STEP_Y);
                        state_next  = DESC_TO_L;
                    end else begin
                        base_x_next = base_x_reg + 10'(STEP_X);
                    end
                end else begin
                    if (left_ext < 11'(X_MIN + STEP_X)) begin
                        base_y_next = base_y_reg + 10'(STEP_Y);
                        state_next  = DESC_TO_R;
                    end else begin
                        base_x_next = base_x_reg - 10'(STEP_X);
                    end
                end
                bottom_ext = {1'b0, base_y_next} + 11'(brow) * 11'(SPACING) + 11'(SPRITE_W);
                if (bottom_ext >= 11'(Y_LIMIT)) begin
                    bottom_next = 1'b1;
                    state_next  = HALT;
                end
            end
            if (kill_valid && (int'(kill_idx) < N)) alive_next[kill_idx] = 1'b0;
            if (alive_next == '0) begin
                clear_next = 1'b1;
                state_next = HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state_reg  <= MARCH_R;
            base_x_reg <= 10'(X_START);
            base_y_reg <= 10'(Y_START);
            alive_reg  <= '1;
            anim_reg   <= 1'b0;
            step_reg   <= 1'b0;
            clear_reg  <= 1'b0;
            bottom_reg <= 1'b0;
            fcnt_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            base_x_reg <= base_x_next;
            base_y_reg <= base_y_next;
            alive_reg  <= alive_next;
            anim_reg   <= anim_next;
            step_reg   <= step_next;
            clear_reg  <= clear_next;
            bottom_reg <= bottom_next;
            fcnt_reg   <= fcnt_next;
        end
    end

    assign base_x         = base_x_reg;
    assign base_y         = base_y_reg;
    assign alive_mask     = alive_reg;
    assign anim_frame     = anim_reg;
    assign step_pulse     = step_reg;
    assign wave_clear     = clear_reg;
    assign reached_bottom = bottom_reg;
endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Directed bench for enemy_formation_ctrl: stepping, edge turns, kills,
// wave clear, bottom halt and reset/restart behaviour.
module tb_enemy_formation_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frame_tick = 1'b0;
    logic        restart = 1'b0;
    logic        kill_valid = 1'b0;
    logic [4:0]  kill_idx = '0;
    logic [9:0]  base_x, base_y;
    logic [31:0] alive_mask;
    logic        anim_frame, step_pulse, wave_clear, reached_bottom;

    int n_cmp = 0;
    int n_err = 0;

    enemy_formation_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .restart(restart),
        .kill_valid(kill_valid), .kill_idx(kill_idx),
        .base_x(base_x), .base_y(base_y), .alive_mask(alive_mask),
        .anim_frame(anim_frame), .step_pulse(step_pulse),
        .wave_clear(wave_clear), .reached_bottom(reached_bottom)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end else begin
            $display("ok   %s: %0d (0x%0h)", tag, got, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic kill(input int idx);
        @(negedge clk) begin kill_valid = 1'b1; kill_idx = 5'(idx); end
        @(negedge clk) kill_valid = 1'b0;
    endtask

    // Step until base_y changes, tracking the horizontal extremes reached
    task automatic run_to_turn(output int max_x, output int min_x);
        int y0;
        y0 = int'(base_y);
        max_x = int'(base_x);
        min_x = int'(base_x);
        for (int s = 0; s < 300 && int'(base_y) == y0; s++) begin
            tick_n(8);
            if (int'(base_x) > max_x) max_x = int'(base_x);
            if (int'(base_x) < min_x) min_x = int'(base_x);
        end
    endtask

    initial begin
        int mx, mn, x_hold;
        // 1: reset values and divide-by-8 stepping
        do_reset();
        check_eq("rst_base_x", 32'(base_x), 64);
        check_eq("rst_base_y", 32'(base_y), 32);
        check_eq("rst_mask", alive_mask, 32'hFFFF_FFFF);
        check_eq("rst_flags", {28'd0, anim_frame, step_pulse, wave_clear, reached_bottom}, 0);
        tick_n(7);
        check_eq("t7_base_x", 32'(base_x), 64);
        check_eq("t7_step", 32'(step_pulse), 0);
        tick_n(1);
        check_eq("t8_base_x", 32'(base_x), 68);
        check_eq("t8_step", 32'(step_pulse), 1);
        check_eq("t8_anim", 32'(anim_frame), 1);
        @(negedge clk);
        check_eq("t8_step_drop", 32'(step_pulse), 0);

        // 2: right turn at 384 (384+224+23 = 631), descend, then left turn at 8
        run_to_turn(mx, mn);
        check_eq("r_turn_max_x", 32'(mx), 384);
        check_eq("r_turn_base_x", 32'(base_x), 384);
        check_eq("r_turn_base_y", 32'(base_y), 48);
        tick_n(8);
        check_eq("l_first_x", 32'(base_x), 380);
        run_to_turn(mx, mn);
        check_eq("l_turn_min_x", 32'(mn), 8);
        check_eq("l_turn_base_y", 32'(base_y), 64);
        check_eq("l_turn_anim", 32'(anim_frame), 0);

        // 3: column 7 dead -> right turn 32 px further
        do_reset();
        kill(7); kill(15); kill(23); kill(31);
        check_eq("col7_mask", alive_mask, 32'h7F7F_7F7F);
        run_to_turn(mx, mn);
        check_eq("col7_max_x", 32'(mx), 416);
        check_eq("col7_base_y", 32'(base_y), 48);

        // 4: kill coincident with step tick, then a repeated kill
        do_reset();
        tick_n(7);
        @(negedge clk) begin frame_tick = 1'b1; kill_valid = 1'b1; kill_idx = 5'd0; end
        @(negedge clk) begin frame_tick = 1'b0; kill_valid = 1'b0; end
        check_eq("co_mask", alive_mask, 32'hFFFF_FFFE);
        check_eq("co_base_x", 32'(base_x), 68);
        kill(0);
        check_eq("rekill_mask", alive_mask, 32'hFFFF_FFFE);
        check_eq("rekill_clear", 32'(wave_clear), 0);

        // 5: wave clear, halt freeze, restart
        do_reset();
        tick_n(8);
        for (int i = 0; i < 31; i++) kill(i);
        check_eq("pre_clear", 32'(wave_clear), 0);
        kill(31);
        check_eq("clear_mask", alive_mask, 0);
        check_eq("clear_flag", 32'(wave_clear), 1);
        tick_n(16);
        check_eq("halt_base_x", 32'(base_x), 68);
        check_eq("halt_base_y", 32'(base_y), 32);
        check_eq("halt_anim", 32'(anim_frame), 1);
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
        check_eq("rs_base_x", 32'(base_x), 64);
        check_eq("rs_base_y", 32'(base_y), 32);
        check_eq("rs_mask", alive_mask, 32'hFFFF_FFFF);
        check_eq("rs_clear", 32'(wave_clear), 0);

        // 6: descend to the bottom line (288+96+24 >= 400) and halt
        do_reset();
        for (int s = 0; s < 2500 && !reached_bottom; s++) tick_n(8);
        check_eq("bot_flag", 32'(reached_bottom), 1);
        check_eq("bot_base_y", 32'(base_y), 288);
        x_hold = int'(base_x);
        tick_n(16);
        kill(5);
        check_eq("bot_freeze_x", 32'(base_x), 32'(x_hold));
        check_eq("bot_freeze_mask", alive_mask, 32'hFFFF_FFFF);

        // reset on a step-tick cycle with a kill overrides everything
        do_reset();
        tick_n(7);
        @(negedge clk) begin frame_tick = 1'b1; kill_valid = 1'b1; kill_idx = 5'd3; reset = 1'b1; end
        @(negedge clk) begin frame_tick = 1'b0; kill_valid = 1'b0; reset = 1'b0; end
        check_eq("mid_rst_x", 32'(base_x), 64);
        check_eq("mid_rst_mask", alive_mask, 32'hFFFF_FFFF);
        check_eq("mid_rst_flags", {28'd0, anim_frame, step_pulse, wave_clear, reached_bottom}, 0);
        tick_n(8);
        check_eq("post_rst_step_x", 32'(base_x), 68);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
